// File: rtl/blockade_pkg.sv
// Shared VRAM geometry and arbiter grant encoding for the Blockade-family core.
package blockade_pkg;

  localparam int unsigned VRAM_ADDR_W = 10;
  localparam int unsigned VRAM_DATA_W = 8;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_VID,
    GNT_CLR,
    GNT_CPU
  } grant_e;

endpackage

// File: rtl/blockade_vram_clear.sv
// Hardware clear/fill engine: walks the whole VRAM once, writing a latched value
// on every cycle the arbiter grants it.
module blockade_vram_clear
  import blockade_pkg::*;
#(
  parameter int unsigned ADDR_W = VRAM_ADDR_W,
  parameter int unsigned DATA_W = VRAM_DATA_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr_start,
  input  logic [DATA_W-1:0] clr_value,
  input  logic              gnt,
  output logic              req,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done
);

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } state_e;

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] value_q, value_d;
  logic              done_q, done_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      value_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      value_q <= value_d;
      done_q  <= done_d;
    end
  end

  // Start is only honoured from idle; the final granted write ends the sweep.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    value_d = value_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (clr_start) begin
          state_d = ST_CLEAR;
          addr_d  = '0;
          value_d = clr_value;
        end
      end
      ST_CLEAR: begin
        if (gnt) begin
          addr_d = addr_q + ADDR_W'(1);
          if (addr_q == LAST_ADDR) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy  = (state_q == ST_CLEAR);
  assign req   = busy;
  assign addr  = addr_q;
  assign wdata = value_q;
  assign done  = done_q;

endmodule

// File: rtl/blockade_vram_arbiter.sv
// Single-port VRAM arbiter: fixed video slot, then clear engine, then CPU with a
// READY-style stall until its access has been acknowledged.
module blockade_vram_arbiter
  import blockade_pkg::*;
#(
  parameter int unsigned ADDR_W = VRAM_ADDR_W,
  parameter int unsigned DATA_W = VRAM_DATA_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ce_vid,
  input  logic              vblank,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [DATA_W-1:0] vid_data,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_ready,
  input  logic              clr_start,
  input  logic [DATA_W-1:0] clr_value,
  output logic              clr_busy,
  output logic              clr_done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  grant_e            gnt;
  logic              live_q;
  logic              cpu_done_q;
  logic              ack_seen_q;
  logic              cpu_gnt_q;
  logic              cpu_rd_q;
  logic              vid_gnt_q;
  logic              clr_req;
  logic              clr_gnt;
  logic [ADDR_W-1:0] clr_addr;
  logic [DATA_W-1:0] clr_wdata;

  blockade_vram_clear #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_clear (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr_start(clr_start),
    .clr_value(clr_value),
    .gnt      (clr_gnt),
    .req      (clr_req),
    .addr     (clr_addr),
    .wdata    (clr_wdata),
    .busy     (clr_busy),
    .done     (clr_done)
  );

  // live_q holds the port idle for the first cycle after reset release.
  always_comb begin
    gnt = GNT_NONE;
    if (live_q) begin
      if (ce_vid && !vblank)          gnt = GNT_VID;
      else if (clr_req)               gnt = GNT_CLR;
      else if (cpu_req && !cpu_done_q) gnt = GNT_CPU;
    end
  end

  assign clr_gnt = (gnt == GNT_CLR);

  always_comb begin
    ram_addr  = vid_addr;
    ram_we    = 1'b0;
    ram_wdata = cpu_wdata;
    unique case (gnt)
      GNT_CLR: begin
        ram_addr  = clr_addr;
        ram_we    = 1'b1;
        ram_wdata = clr_wdata;
      end
      GNT_CPU: begin
        ram_addr = cpu_addr;
        ram_we   = cpu_we;
      end
      default: ;
    endcase
  end

  // The ack cycle itself already counts as seen, so READY rises with the ack.
  assign cpu_ready = !reset_n || !(cpu_req && !(ack_seen_q || cpu_ack));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      live_q     <= 1'b0;
      cpu_done_q <= 1'b0;
      ack_seen_q <= 1'b0;
      cpu_gnt_q  <= 1'b0;
      cpu_rd_q   <= 1'b0;
      vid_gnt_q  <= 1'b0;
      cpu_ack    <= 1'b0;
      cpu_rdata  <= '0;
      vid_data   <= '0;
    end else begin
      live_q    <= 1'b1;
      cpu_gnt_q <= (gnt == GNT_CPU);
      cpu_rd_q  <= (gnt == GNT_CPU) && !cpu_we;
      vid_gnt_q <= (gnt == GNT_VID);
      cpu_ack   <= cpu_gnt_q;

      if (gnt == GNT_CPU)  cpu_done_q <= 1'b1;
      else if (!cpu_req)   cpu_done_q <= 1'b0;

      if (!cpu_req)        ack_seen_q <= 1'b0;
      else if (cpu_ack)    ack_seen_q <= 1'b1;

      if (cpu_rd_q)  cpu_rdata <= ram_rdata;
      if (vid_gnt_q) vid_data  <= ram_rdata;
    end
  end

endmodule

// File: tb/tb_blockade_vram_arbiter.sv
// Scoreboard bench for the VRAM arbiter with a behavioural 1024x8 synchronous RAM.
module tb_blockade_vram_arbiter;

  logic        clk;
  logic        reset_n;
  logic        ce_vid;
  logic        vblank;
  logic [9:0]  vid_addr;
  logic [7:0]  vid_data;
  logic        cpu_req;
  logic        cpu_we;
  logic [9:0]  cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_ack;
  logic        cpu_ready;
  logic        clr_start;
  logic [7:0]  clr_value;
  logic        clr_busy;
  logic        clr_done;
  logic [9:0]  ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;

  blockade_vram_arbiter dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .ce_vid   (ce_vid),
    .vblank   (vblank),
    .vid_addr (vid_addr),
    .vid_data (vid_data),
    .cpu_req  (cpu_req),
    .cpu_we   (cpu_we),
    .cpu_addr (cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata),
    .cpu_ack  (cpu_ack),
    .cpu_ready(cpu_ready),
    .clr_start(clr_start),
    .clr_value(clr_value),
    .clr_busy (clr_busy),
    .clr_done (clr_done),
    .ram_addr (ram_addr),
    .ram_we   (ram_we),
    .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  typedef struct {
    int         due;
    logic [7:0] val;
  } vexp_t;

  int          total;
  int          bad;
  int          cyc;
  int          wr_cnt;
  int          acc_cnt;
  int          ack_cnt;
  bit          vid_en;
  bit          init_mem;
  logic [1:0]  ph;
  logic [7:0]  mem [1024];
  vexp_t       vq[$];
  logic [17:0] wq[$];
  vexp_t       ve;
  logic [17:0] we_exp;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural RAM: one-cycle read latency, read-before-write.
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
      mem[10'h123] <= 8'h5A;
      mem[10'h3FF] <= 8'hC3;
    end else if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
    ram_rdata <= mem[ram_addr];
  end

  initial begin
    ce_vid = 1'b0;
    ph     = 2'd0;
    forever begin
      @(posedge clk);
      #1;
      ph     = ph + 2'd1;
      ce_vid = vid_en && (ph == 2'd0);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Scoreboard monitor: video read-backs and RAM writes.
  always @(negedge clk) begin
    if (reset_n) begin
      while (vq.size() > 0 && vq[0].due <= cyc) begin
        ve = vq.pop_front();
        check_eq("vid_data", 32'(vid_data), 32'(ve.val));
      end
      if (ce_vid && !vblank) vq.push_back('{cyc + 2, mem[vid_addr]});
      if (ram_we) begin
        wr_cnt++;
        if (wq.size() == 0) begin
          check_eq("unexp_we", 32'(ram_we), 32'd0);
        end else begin
          we_exp = wq.pop_front();
          check_eq("wr_addr_data", 32'({ram_addr, ram_wdata}), 32'(we_exp));
        end
      end
      if (ram_addr == 10'h3FF && !ram_we && !(ce_vid && !vblank)) acc_cnt++;
      if (cpu_ack) ack_cnt++;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push_clear(input logic [7:0] v);
    for (int i = 0; i < 1024; i++) wq.push_back({10'(i), v});
  endtask

  task automatic cpu_access(input string tag, input logic we, input logic [9:0] a,
                            input logic [7:0] d, input bit sync_vid, input int exp_lat,
                            input logic [7:0] exp_rd);
    int lat;
    int rdy_lo;
    if (sync_vid) for (int i = 0; i < 8 && !ce_vid; i++) step();
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = a;
    cpu_wdata = d;
    if (we) wq.push_back({a, d});
    lat    = 0;
    rdy_lo = 0;
    @(negedge clk);
    while (!cpu_ack && lat < 200) begin
      if (!cpu_ready) rdy_lo++;
      lat++;
      @(negedge clk);
    end
    check_eq({tag, "_ack_lat"}, 32'(lat), 32'(exp_lat));
    check_eq({tag, "_ready_low"}, 32'(rdy_lo), 32'(exp_lat));
    check_eq({tag, "_ready_at_ack"}, 32'(cpu_ready), 32'd1);
    if (!we) check_eq({tag, "_rdata"}, 32'(cpu_rdata), 32'(exp_rd));
    step();
    cpu_req = 1'b0;
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, k0, w0, busy_cnt, slot_cnt, bad_slot, done_cnt, wr_busy, fall_i, ack_i, n;
    total = 0; bad = 0; cyc = 0; wr_cnt = 0; acc_cnt = 0; ack_cnt = 0;
    vid_en = 1'b0; init_mem = 1'b1;
    reset_n = 1'b0; vblank = 1'b1; vid_addr = 10'h123;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h0; cpu_wdata = 8'h0;
    clr_start = 1'b0; clr_value = 8'h0;

    // Reset state
    step();
    check_eq("rst_vid_data", 32'(vid_data), 32'd0);
    check_eq("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
    check_eq("rst_cpu_ack", 32'(cpu_ack), 32'd0);
    check_eq("rst_cpu_ready", 32'(cpu_ready), 32'd1);
    check_eq("rst_clr_busy", 32'(clr_busy), 32'd0);
    check_eq("rst_ram_we", 32'(ram_we), 32'd0);
    cpu_req = 1'b0;
    step();
    init_mem = 1'b0;
    reset_n  = 1'b1;
    step();

    // Video only
    vblank = 1'b0;
    vid_en = 1'b1;
    repeat (40) step();

    // CPU write colliding with a video slot
    cpu_access("coll_wr", 1'b1, 10'h010, 8'hA5, 1'b1, 3, 8'h00);

    // CPU read held high for 20 cycles: a single access
    a0 = acc_cnt; k0 = ack_cnt;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h3FF;
    repeat (20) step();
    check_eq("held_acc_cnt", 32'(acc_cnt - a0), 32'd1);
    check_eq("held_ack_cnt", 32'(ack_cnt - k0), 32'd1);
    check_eq("held_rdata", 32'(cpu_rdata), 32'hC3);
    check_eq("held_ready", 32'(cpu_ready), 32'd1);
    cpu_req = 1'b0;
    step();
    cpu_req = 1'b1;
    repeat (6) step();
    check_eq("rereq_acc_cnt", 32'(acc_cnt - a0), 32'd2);
    check_eq("rereq_ack_cnt", 32'(ack_cnt - k0), 32'd2);
    cpu_req = 1'b0;
    repeat (2) step();

    // Clear during vblank with a concurrent CPU read
    vblank = 1'b1;
    repeat (4) step();
    clr_value = 8'h20; clr_start = 1'b1;
    push_clear(8'h20);
    step();
    clr_start = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h3FF;
    busy_cnt = 0; done_cnt = 0; wr_busy = 0; fall_i = -1; ack_i = -1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (clr_busy) busy_cnt++;
      if (clr_busy && ram_we) wr_busy++;
      if (clr_done) done_cnt++;
      if (!clr_busy && busy_cnt > 0 && fall_i < 0) fall_i = i;
      if (cpu_ack) begin
        ack_i = i;
        break;
      end
    end
    check_eq("vb_busy_cycles", 32'(busy_cnt), 32'd1024);
    check_eq("vb_writes_in_busy", 32'(wr_busy), 32'd1024);
    check_eq("vb_done_pulses", 32'(done_cnt), 32'd1);
    check_eq("vb_cpu_after_clear", 32'(ack_i - fall_i), 32'd2);
    check_eq("vb_cpu_rdata", 32'(cpu_rdata), 32'h20);
    check_eq("vb_wq_empty", 32'(wq.size()), 32'd0);
    step();
    cpu_req = 1'b0;
    repeat (2) step();

    // Clear during active video, second start mid-clear ignored
    vblank = 1'b0;
    repeat (3) step();
    clr_value = 8'h77; clr_start = 1'b1;
    push_clear(8'h77);
    step();
    clr_start = 1'b0;
    w0 = wr_cnt; busy_cnt = 0; slot_cnt = 0; bad_slot = 0; n = 0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (clr_busy) begin
        busy_cnt++;
        if (ce_vid && !vblank) begin
          slot_cnt++;
          if (ram_we || ram_addr != vid_addr) bad_slot++;
        end
      end
      if (i == 300) begin clr_start = 1'b1; clr_value = 8'h11; end
      if (i == 301) clr_start = 1'b0;
      if (clr_done) begin
        n = 1;
        break;
      end
    end
    check_eq("av_done_seen", 32'(n), 32'd1);
    check_eq("av_busy_minus_slots", 32'(busy_cnt - slot_cnt), 32'd1024);
    check_eq("av_slot_violations", 32'(bad_slot), 32'd0);
    repeat (10) step();
    check_eq("av_total_writes", 32'(wr_cnt - w0), 32'd1024);
    check_eq("av_wq_empty", 32'(wq.size()), 32'd0);

    // Reset mid-clear at address 0x200
    vblank = 1'b1;
    repeat (4) step();
    clr_value = 8'h44; clr_start = 1'b1;
    push_clear(8'h44);
    step();
    clr_start = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h3FF;
    n = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (ram_we && ram_addr == 10'h200) begin
        n = 1;
        break;
      end
    end
    check_eq("rc_reached_200", 32'(n), 32'd1);
    #1;
    reset_n = 1'b0;
    #1;
    check_eq("rc_clr_busy", 32'(clr_busy), 32'd0);
    check_eq("rc_cpu_ready", 32'(cpu_ready), 32'd1);
    check_eq("rc_vid_data", 32'(vid_data), 32'd0);
    check_eq("rc_ram_we", 32'(ram_we), 32'd0);
    check_eq("rc_clr_done", 32'(clr_done), 32'd0);
    wq.delete();
    vq.delete();
    cpu_req = 1'b0;
    repeat (2) step();
    reset_n = 1'b1;
    w0 = wr_cnt;
    repeat (40) step();
    check_eq("rc_no_writes", 32'(wr_cnt - w0), 32'd0);
    check_eq("rc_busy_after", 32'(clr_busy), 32'd0);

    // Plain accesses after reset, no conflicts
    cpu_access("post_rd1", 1'b0, 10'h001, 8'h00, 1'b0, 2, 8'h44);
    cpu_access("post_wr", 1'b1, 10'h155, 8'h9C, 1'b0, 2, 8'h00);
    cpu_access("post_rd", 1'b0, 10'h155, 8'h00, 1'b0, 2, 8'h9C);
    check_eq("end_wq_empty", 32'(wq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
